// File: rtl/string_method_arb_pkg.sv
// string_method_arb_pkg: opcode and FSM state types plus sizing constants
// shared by the string-method arbiter, its interface and its method unit.
package string_method_arb_pkg;

  localparam int NREQ         = 2;
  localparam int EXEC_LAT_MAX = 15;
  localparam int CNT_W        = $clog2(EXEC_LAT_MAX + 1);

  typedef enum logic [3:0] {
    OP_LEN      = 4'd0,
    OP_TOUPPER  = 4'd1,
    OP_TOLOWER  = 4'd2,
    OP_PUTC     = 4'd3,
    OP_GETC     = 4'd4,
    OP_COMPARE  = 4'd5,
    OP_ICOMPARE = 4'd6,
    OP_SUBSTR   = 4'd7,
    OP_ATOI     = 4'd8,
    OP_ATOHEX   = 4'd9,
    OP_ITOA     = 4'd10,
    OP_HEXTOA   = 4'd11,
    OP_BINTOA   = 4'd12,
    OP_RSV13    = 4'd13,
    OP_RSV14    = 4'd14,
    OP_RSV15    = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

endpackage

// File: rtl/string_method_arb_if.sv
// string_method_arb_if: per-requester command channels and the shared
// response channel of the string-method arbiter.
interface string_method_arb_if;
  import string_method_arb_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  op_t                req_op [NREQ];
  string              req_s  [NREQ];
  string              req_t  [NREQ];
  logic signed [31:0] req_a  [NREQ];
  logic signed [31:0] req_b  [NREQ];

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  string              rsp_s;
  logic signed [31:0] rsp_i;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_s, req_t, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_i, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_s, req_t, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_s, rsp_i, rsp_err
  );

endinterface

// File: rtl/string_method_unit.sv
// string_method_unit: combinational evaluation of one string-method opcode
// on captured operands; out-of-range arguments leave the defaults in place.
module string_method_unit
  import string_method_arb_pkg::*;
(
  input  op_t                op,
  input  string              s,
  input  string              t,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output string              rsp_s,
  output logic signed [31:0] rsp_i,
  output logic               err
);

  string work;
  int    slen;
  int    cmp;

  always_comb begin
    rsp_s = s;
    rsp_i = '0;
    err   = 1'b0;
    work  = s;
    slen  = s.len();
    cmp   = 0;
    case (op)
      OP_LEN:     rsp_i = slen;
      OP_TOUPPER: rsp_s = s.toupper();
      OP_TOLOWER: rsp_s = s.tolower();
      OP_PUTC: begin
        if (a >= 0 && a < slen && b[7:0] != 8'h00) begin
          work.putc(a, b[7:0]);
          rsp_s = work;
        end
      end
      OP_GETC: begin
        if (a >= 0 && a < slen) rsp_i = {24'h0, s.getc(a)};
      end
      OP_COMPARE, OP_ICOMPARE: begin
        // Raw compare magnitudes are tool dependent, so only the sign is kept.
        cmp   = (op == OP_COMPARE) ? s.compare(t) : s.icompare(t);
        rsp_i = (cmp < 0) ? -32'sd1 : ((cmp > 0) ? 32'sd1 : 32'sd0);
      end
      OP_SUBSTR: begin
        if (a < 0 || b < a || b >= slen) rsp_s = "";
        else                             rsp_s = s.substr(a, b);
      end
      OP_ATOI:    rsp_i = 32'(s.atoi());
      OP_ATOHEX:  rsp_i = 32'(s.atohex());
      OP_ITOA:    rsp_s = $sformatf("%0d", a);
      OP_HEXTOA:  rsp_s = $sformatf("%0h", a);
      OP_BINTOA:  rsp_s = $sformatf("%0b", a);
      default:    err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/string_method_arb.sv
// string_method_arb: round-robin arbiter/sequencer sharing one string-method unit
// between two requesters. Define STRING_METHOD_ARB_STATS_EN for grant counters.
module string_method_arb
  import string_method_arb_pkg::*;
#(
  parameter int EXEC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  string_method_arb_if.slave        bus
`ifdef STRING_METHOD_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]     grant_cnt
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               last_q;
  logic               win;
  logic               accept;
  logic [CNT_W-1:0]   cnt_q;
  logic               exec_done;

  logic               id_q;
  op_t                op_q;
  string              s_q;
  string              t_q;
  logic signed [31:0] a_q;
  logic signed [31:0] b_q;

  string              unit_s;
  logic signed [31:0] unit_i;
  logic               unit_err;

  assign exec_done = (cnt_q == CNT_W'(EXEC_LAT - 1));

  // Contention goes to the requester that did not win last time.
  always_comb begin
    win = 1'b0;
    if (bus.req_valid == 2'b11) win = ~last_q;
    else if (bus.req_valid[1])  win = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!reset && bus.req_valid != '0) begin
          bus.req_ready = win ? 2'b10 : 2'b01;
          accept        = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) state_d = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = !reset;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Response registers only load on the last EXEC cycle, which keeps them
  // stable for the whole RESP phase regardless of rsp_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      op_q        <= OP_LEN;
      s_q         <= "";
      t_q         <= "";
      a_q         <= '0;
      b_q         <= '0;
      bus.rsp_id  <= 1'b0;
      bus.rsp_s   <= "";
      bus.rsp_i   <= '0;
      bus.rsp_err <= 1'b0;
    end else if (accept) begin
      last_q <= win;
      cnt_q  <= '0;
      id_q   <= win;
      op_q   <= bus.req_op[win];
      s_q    <= bus.req_s[win];
      t_q    <= bus.req_t[win];
      a_q    <= bus.req_a[win];
      b_q    <= bus.req_b[win];
    end else if (state_q == S_EXEC) begin
      cnt_q <= cnt_q + 1'b1;
      if (exec_done) begin
        bus.rsp_id  <= id_q;
        bus.rsp_s   <= unit_s;
        bus.rsp_i   <= unit_i;
        bus.rsp_err <= unit_err;
      end
    end
  end

  string_method_unit u_unit (
    .op    (op_q),
    .s     (s_q),
    .t     (t_q),
    .a     (a_q),
    .b     (b_q),
    .rsp_s (unit_s),
    .rsp_i (unit_i),
    .err   (unit_err)
  );

`ifdef STRING_METHOD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (accept && grant_cnt[win] != 16'hFFFF) begin
      grant_cnt[win] <= grant_cnt[win] + 16'd1;
    end
  end
`endif

endmodule

// File: doc/string_method_arb.md
# string_method_arb

Round-robin arbiter and sequencer that shares one SystemVerilog string-method execution unit between two requesters. It accepts one command at a time over a valid/ready handshake and holds it for a fixed execution latency. It then returns the result with the requester's id over a valid/ready response channel. It sits in the regression string-test infrastructure between cycle-driven stimulus generators and the single shared method unit.

## Interface
- `EXEC_LAT`, default 2: cycles spent in EXEC; legal range 1..15.
- `clk`  in  1  clock; all logic is on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  [1:0]  per-requester command valid.
- `req_ready`  out  [1:0]  per-requester accept strobe; at most one bit is high.
- `req_op`  in  2 x op_t (4b)  opcode, one per requester.
- `req_s`  in  2 x string  primary operand string.
- `req_t`  in  2 x string  second string, used by COMPARE and ICOMPARE.
- `req_a`  in  2 x 32 signed  integer argument a.
- `req_b`  in  2 x 32 signed  integer argument b.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  id of the requester that issued the command.
- `rsp_s`  out  string  string result.
- `rsp_i`  out  32 signed  integer result.
- `rsp_err`  out  1  illegal opcode flag.
- `grant_cnt`  out  2 x 16  per-requester grant counters; present only with the `STRING_METHOD_ARB_STATS_EN` macro.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is high, the winner's `req_ready` bit is driven high combinationally.
  - Command accepted on `req_valid[w] & req_ready[w]`; all operands captured; go to EXEC.
- Arbitration: round-robin with a one-bit pointer `last`. If both requesters are valid, grant `!last`. If only one is valid, grant it. `last` updates to the winner on accept.
- EXEC: counter runs `EXEC_LAT` cycles. On the final cycle the result is registered; go to RESP.
- RESP: `rsp_valid`=1; outputs held stable until `rsp_ready`. On `rsp_valid & rsp_ready`, go to IDLE. No new accept occurs in that same cycle.
- Opcodes (`rsp_s` defaults to captured `s`; `rsp_i` defaults to 0):
  - LEN=0: `rsp_i`=len.
  - TOUPPER=1, TOLOWER=2: case-converted string in `rsp_s`.
  - PUTC=3: index `a`, char `b[7:0]`. No change if `a`<0, `a`>=len, or the char is 0.
  - GETC=4: `rsp_i`=zero-extended byte; 0 if out of range.
  - COMPARE=5, ICOMPARE=6: `rsp_i` normalized to -1/0/1.
  - SUBSTR=7: range a..b; result "" if a<0, b<a, or b>=len.
  - ATOI=8, ATOHEX=9: `rsp_i`=parsed value, truncated to 32 bits.
  - ITOA=10, HEXTOA=11, BINTOA=12: `rsp_s`=formatted `a`, lowercase hex, no leading zeros.
  - 13..15: `rsp_err`=1; `rsp_s`=`s` unchanged; `rsp_i`=0.
- Reset (including mid-EXEC or mid-RESP):
  - FSM returns to IDLE; any in-flight response is dropped.
  - `last`=1, so requester 0 wins first.
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`="", `rsp_i`=0, `rsp_err`=0, `grant_cnt`=0.

## Timing
- Accept at cycle N; `rsp_valid` first high at N+1+`EXEC_LAT`.
- With `rsp_ready` tied high, throughput is one command per `EXEC_LAT`+2 cycles.
- `req_ready` is never asserted outside IDLE.
- A requester that drops `req_valid` before acceptance loses nothing; no state changes.
- A grant does not depend on `rsp_ready`.
- `rsp_*` outputs do not change while `rsp_valid & !rsp_ready`.

## Configuration
- `STRING_METHOD_ARB_STATS_EN` defined:
  - `grant_cnt[i]` increments on each accept by requester i.
  - Counters saturate at 16'hFFFF and clear on reset.
- Macro undefined: the counters and the `grant_cnt` port are absent; all other behaviour is identical.

## Structure
- Package `string_method_arb_pkg`:
  - `op_t` enum with the OP_* values above.
  - `NREQ`=2.
  - `EXEC_LAT_MAX`=15.
- Sub-module `string_method_unit`: purely combinational; maps op, s, t, a, b to rsp_s, rsp_i, err.
- Top level holds the FSM, arbiter pointer, operand registers, latency counter and stats.

## Test plan
- Req0 only: GETC on "1234", a=2 -> after 1+`EXEC_LAT` cycles, `rsp_id`=0, `rsp_i`=8'h33.
- Both valid every cycle, `rsp_ready`=1, 6 commands -> grants alternate 0,1,0,1,0,1. With stats enabled, each `grant_cnt`=3.
- PUTC on "1234" with a=-1, then a=4, then b=0, then a=2 with b="z" -> `rsp_s`="1234", "1234", "1234", "12z4".
- SUBSTR on "abcd" with (-1,1), (1,0), (1,4), (2,3) -> "", "", "", "cd". ITOA, HEXTOA, BINTOA with a=123 -> "123", "7b", "1111011".
- `rsp_ready` held low 5 cycles in RESP -> outputs stable and `req_ready`=0 throughout; req1 waiting is granted the cycle after handshake completes.
- Reset asserted during EXEC -> next cycle `rsp_valid`=0 and outputs at reset values. With both requesters valid afterwards, requester 0 wins. Opcode 14 -> `rsp_err`=1.
